ram1_bus_arbiter: RTL and testbench
===================================

Name: ram1_bus_arbiter

Overview:
- Sequencer and arbiter for the shared RAM1 SRAM / UART bus.
- Arbitrates between the instruction-fetch port and the data (MEM-stage) port.
- Generates the cycle-accurate active-low SRAM and UART strobes.
- Decodes the UART data and status addresses.
- Replaces the ad-hoc strobe logic so fetch and data accesses can share one physical RAM.

Parameters:
UART_DATA_ADDR, 16'hBF00, data address mapped to the UART data register
UART_STAT_ADDR, 16'hBF01, data address mapped to the UART status register
WR_PULSE_CYC, 2, cycles ram_we_n / uart_wrn is held low (1..7)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  16  fetch word address
if_ack  out  1  one-cycle completion pulse for fetch
if_rdata  out  16  fetched word
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  16  data word address
d_wdata  in  16  write data
d_ack  out  1  one-cycle completion pulse for data
d_rdata  out  16  read data
ram_en_n  out  1  SRAM chip enable, active-low
ram_oe_n  out  1  SRAM output enable, active-low
ram_we_n  out  1  SRAM write enable, active-low
ram_addr  out  18  SRAM address
ram_dout  out  16  value driven onto the shared data bus
ram_dout_en  out  1  1 = this block drives the bus
ram_din  in  16  sampled value of the shared data bus
uart_data_ready  in  1  UART has a received byte
uart_tbre  in  1  UART transmit buffer empty
uart_tsre  in  1  UART transmit shift register empty
uart_rdn  out  1  UART read strobe, active-low
uart_wrn  out  1  UART write strobe, active-low
busy  out  1  state != IDLE

Behaviour:
Reset:
- State IDLE.
- ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn = 1.
- ram_dout_en = 0; ram_addr, ram_dout, if_rdata, d_rdata = 0; acks = 0.
- last_grant = fetch.
- Assertion mid-transaction releases all strobes and the bus immediately (asynchronous); the transaction is lost and no ack is issued.

Arbitration (IDLE only, per cycle):
- Only d_req: grant data. Only if_req: grant fetch.
- Both: grant fetch if last_grant == data, else grant data, so neither port starves.
- On grant: latch address, we, wdata and port id; set last_grant. Later changes on the request inputs are ignored.
- ram_addr = {2'b00, latched addr}.

Transaction sequences (one state per cycle; each ends in DONE):
- SRAM read: RD1, RD2, DONE.
  - RD1/RD2: en_n = 0, oe_n = 0.
  - ram_din is captured into the port's rdata at the edge ending RD2.
  - Grant edge to ack = 3 cycles.
- SRAM write: WR_SETUP, WR_PULSE x WR_PULSE_CYC, WR_HOLD, DONE.
  - ram_dout_en = 1 and en_n = 0 throughout; we_n = 0 only in WR_PULSE.
  - Data is held for one cycle after we_n rises.
- UART data read (data port, addr == UART_DATA_ADDR, !we): UR1, UR2, DONE.
  - SRAM stays disabled; uart_rdn = 0 in UR1/UR2.
  - d_rdata = {8'h00, ram_din[7:0]}, captured at the end of UR2.
  - Performed regardless of uart_data_ready.
- UART data write: UW_PULSE x WR_PULSE_CYC, UW_HOLD, DONE.
  - ram_dout_en = 1; uart_wrn = 0 only in UW_PULSE; ram_dout = {8'h00, wdata[7:0]}.
- Status read (addr == UART_STAT_ADDR, !we): straight to DONE.
  - d_rdata = {14'b0, uart_data_ready, uart_tbre & uart_tsre}, sampled at the grant edge.
- Status write: no bus activity, DONE with ack.
- Fetch addresses are never decoded as UART; fetch is always an SRAM read.

DONE state:
- The granted port's ack = 1 for exactly one cycle; all strobes inactive; ram_dout_en = 0; next state IDLE.
- Requests are not sampled in DONE; earliest next grant is in the following IDLE cycle, so back-to-back transactions have a 1-cycle gap.
- rdata holds its value until the next read on the same port completes.
- Writes leave rdata unchanged.

Other rules:
- Request withdrawn before ack is illegal; the transaction completes and ack still pulses.
- ram_dout_en and ram_oe_n = 0 are never asserted in the same cycle.

Test Plan:
1. Reset, then if_req with if_addr = 16'h0010, SRAM model returns 16'h1234 -> en_n/oe_n low for 2 cycles, ram_addr = 18'h00010, if_ack 3 cycles after grant, if_rdata = 16'h1234.
2. d_req write, d_addr = 16'h8000, d_wdata = 16'hABCD -> ram_we_n low exactly 2 cycles, ram_dout = 16'hABCD with dout_en high from WR_SETUP through WR_HOLD, d_ack, memory holds 16'hABCD.
3. Both req held continuously -> grants alternate data, fetch, data, fetch; each ack arrives in the correct order with the correct data.
4. Status read with tbre = 1, tsre = 1, data_ready = 1 -> d_ack one cycle after grant, d_rdata = 16'h0003; repeat with tsre = 0, data_ready = 0 -> 16'h0000.
5. UART write of d_wdata = 16'h1241 -> uart_wrn low 2 cycles, ram_dout = 16'h0041, ram_en_n stays 1; UART read with bus = 16'hFF5A -> d_rdata = 16'h005A.
6. RST asserted during WR_PULSE -> ram_we_n = 1 and ram_dout_en = 0 immediately, no ack; after release, a new fetch completes normally.

Source files
------------

// File: rtl/ram1_bus_arbiter.sv
// Shared RAM1 SRAM / UART bus sequencer. Arbitrates between the instruction
// fetch port and the data port, then plays out a fixed, cycle-accurate strobe
// sequence for the granted access and pulses that port's ack in DONE.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a request; arbitration happens here only
// S_RD1      | SRAM read, first cycle with en_n/oe_n low
// S_RD2      | SRAM read, second cycle; ram_din captured at its end
// S_WR_SETUP | SRAM write, data and en_n driven, we_n still high
// S_WR_PULSE | SRAM write, we_n low for WR_PULSE_CYC cycles
// S_WR_HOLD  | SRAM write, we_n high again, data still driven
// S_UR1      | UART data read, uart_rdn low
// S_UR2      | UART data read, uart_rdn low; low byte captured at its end
// S_UW_PULSE | UART data write, uart_wrn low for WR_PULSE_CYC cycles
// S_UW_HOLD  | UART data write, uart_wrn high, data still driven
// S_DONE     | one-cycle ack for the granted port, bus released
module ram1_bus_arbiter #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned WR_PULSE_CYC   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  output logic        ram_dout_en,
  input  logic [15:0] ram_din,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre,
  output logic        uart_rdn,
  output logic        uart_wrn,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_UR1,
    S_UR2,
    S_UW_PULSE,
    S_UW_HOLD,
    S_DONE
  } state_t;

  // Pulse timer is a down-counter loaded with (cycles - 1); terminal count is 0.
  localparam logic [2:0] PULSE_LOAD = 3'(WR_PULSE_CYC - 1);

  state_t     state;
  logic [2:0] pulse_cnt;
  logic       sel_data;    // 1 = current transaction belongs to the data port
  logic       last_grant;  // 1 = data was granted most recently

  logic grant_any;
  logic grant_data;

  // Data wins a tie only if fetch went last, so the two ports alternate.
  assign grant_any  = if_req | d_req;
  assign grant_data = d_req & (~if_req | ~last_grant);
  assign busy       = (state != S_IDLE);

  // Sequencer: strobes are registered and set for the state being entered,
  // so every output defaults to inactive and each arm re-asserts what it needs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      pulse_cnt   <= '0;
      sel_data    <= 1'b0;
      last_grant  <= 1'b0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      ram_en_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_addr    <= '0;
      ram_dout    <= '0;
      ram_dout_en <= 1'b0;
      uart_rdn    <= 1'b1;
      uart_wrn    <= 1'b1;
    end else begin
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      ram_en_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_dout_en <= 1'b0;
      uart_rdn    <= 1'b1;
      uart_wrn    <= 1'b1;

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            sel_data   <= grant_data;
            last_grant <= grant_data;
            if (grant_data) begin
              ram_addr <= {2'b00, d_addr};
              if (d_addr == UART_STAT_ADDR) begin
                // Status access completes immediately; writes are discarded.
                state <= S_DONE;
                d_ack <= 1'b1;
                if (!d_we) begin
                  d_rdata <= {14'b0, uart_data_ready, uart_tbre & uart_tsre};
                end
              end else if (d_addr == UART_DATA_ADDR) begin
                if (d_we) begin
                  state       <= S_UW_PULSE;
                  pulse_cnt   <= PULSE_LOAD;
                  uart_wrn    <= 1'b0;
                  ram_dout_en <= 1'b1;
                  ram_dout    <= {8'h00, d_wdata[7:0]};
                end else begin
                  state    <= S_UR1;
                  uart_rdn <= 1'b0;
                end
              end else if (d_we) begin
                state       <= S_WR_SETUP;
                ram_en_n    <= 1'b0;
                ram_dout_en <= 1'b1;
                ram_dout    <= d_wdata;
              end else begin
                state    <= S_RD1;
                ram_en_n <= 1'b0;
                ram_oe_n <= 1'b0;
              end
            end else begin
              // Fetch is never UART-decoded: always a plain SRAM read.
              ram_addr <= {2'b00, if_addr};
              state    <= S_RD1;
              ram_en_n <= 1'b0;
              ram_oe_n <= 1'b0;
            end
          end
        end

        S_RD1: begin
          state    <= S_RD2;
          ram_en_n <= 1'b0;
          ram_oe_n <= 1'b0;
        end

        S_RD2: begin
          state <= S_DONE;
          if (sel_data) begin
            d_rdata <= ram_din;
            d_ack   <= 1'b1;
          end else begin
            if_rdata <= ram_din;
            if_ack   <= 1'b1;
          end
        end

        S_WR_SETUP: begin
          state       <= S_WR_PULSE;
          pulse_cnt   <= PULSE_LOAD;
          ram_en_n    <= 1'b0;
          ram_dout_en <= 1'b1;
          ram_we_n    <= 1'b0;
        end

        S_WR_PULSE: begin
          ram_en_n    <= 1'b0;
          ram_dout_en <= 1'b1;
          if (pulse_cnt == 3'd0) begin
            state <= S_WR_HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - 3'd1;
            ram_we_n  <= 1'b0;
          end
        end

        S_WR_HOLD: begin
          state <= S_DONE;
          d_ack <= 1'b1;
        end

        S_UR1: begin
          state    <= S_UR2;
          uart_rdn <= 1'b0;
        end

        S_UR2: begin
          state   <= S_DONE;
          d_rdata <= {8'h00, ram_din[7:0]};
          d_ack   <= 1'b1;
        end

        S_UW_PULSE: begin
          ram_dout_en <= 1'b1;
          if (pulse_cnt == 3'd0) begin
            state <= S_UW_HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - 3'd1;
            uart_wrn  <= 1'b0;
          end
        end

        S_UW_HOLD: begin
          state <= S_DONE;
          d_ack <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// Self-checking bench for ram1_bus_arbiter: SRAM model on the shared bus,
// strobe monitor, and a transaction-level reference model.
module tb_ram1_bus_arbiter;

  localparam logic [15:0] UDATA = 16'hBF00;
  localparam logic [15:0] USTAT = 16'hBF01;
  localparam int          NP    = 2;

  logic        CLK, RST;
  logic        if_req, if_ack, d_req, d_we, d_ack;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        ram_en_n, ram_oe_n, ram_we_n, ram_dout_en;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout, ram_din;
  logic        uart_data_ready, uart_tbre, uart_tsre, uart_rdn, uart_wrn, busy;
  logic [15:0] uart_bus;

  int errors = 0;
  int checks = 0;

  ram1_bus_arbiter #(
    .UART_DATA_ADDR(UDATA),
    .UART_STAT_ADDR(USTAT),
    .WR_PULSE_CYC  (NP)
  ) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_en(ram_dout_en),
    .ram_din(ram_din),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- SRAM model on the shared bus ----------------
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : ((a ^ 16'h5A5A) + {a[7:0], a[15:8]});
  endfunction

  logic [15:0] mem [65536];
  bit          wr_valid [65536];

  assign ram_din = (!ram_en_n && !ram_oe_n)
                 ? (wr_valid[ram_addr[15:0]] ? mem[ram_addr[15:0]] : init_val(ram_addr[15:0]))
                 : uart_bus;

  always @(posedge CLK) begin
    if (!ram_en_n && !ram_we_n && ram_dout_en) begin
      mem[ram_addr[15:0]]      <= ram_dout;
      wr_valid[ram_addr[15:0]] <= 1'b1;
    end
  end

  // ---------------- strobe monitor (cumulative counters) ----------------
  int n_en = 0, n_oe = 0, n_we = 0, n_rdn = 0, n_wrn = 0, n_dout = 0;
  int n_conflict = 0, n_dack = 0, n_iack = 0;
  logic [15:0] we_dout = '0, wrn_dout = '0;
  logic [17:0] rd_addr = '0;

  always @(negedge CLK) begin
    if (!ram_en_n) n_en++;
    if (!ram_oe_n) n_oe++;
    if (!ram_we_n) begin n_we++; we_dout = ram_dout; end
    if (!uart_rdn) n_rdn++;
    if (!uart_wrn) begin n_wrn++; wrn_dout = ram_dout; end
    if (ram_dout_en) n_dout++;
    if (ram_dout_en && !ram_oe_n) n_conflict++;
    if (!ram_en_n && !ram_oe_n) rd_addr = ram_addr;
    if (d_ack) n_dack++;
    if (if_ack) n_iack++;
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_if = '0, exp_d = '0, exp_tx = '0;
  bit          ref_last = 1'b0;  // 1 = data port granted last

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int exp_lat(input bit pd, input bit we, input logic [15:0] a);
    if (!pd)        return 3;
    if (a == USTAT) return 1;
    if (a == UDATA) return we ? NP + 2 : 3;
    return we ? NP + 3 : 3;
  endfunction

  task automatic ref_apply(input bit pd, input bit we, input logic [15:0] a, input logic [15:0] wd);
    ref_last = pd;
    if (!pd) exp_if = mem_val(a);
    else if (a == USTAT) begin
      if (!we) exp_d = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
    end else if (a == UDATA) begin
      if (we) exp_tx = {8'h00, wd[7:0]};
      else    exp_d  = {8'h00, uart_bus[7:0]};
    end else begin
      if (we) ref_mem[a] = wd;
      else    exp_d = mem_val(a);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Drives one transaction from IDLE, scrambles the request inputs after the
  // grant edge, waits (bounded) for the ack and leaves the DUT back in IDLE.
  task automatic run_txn(input bit pd, input bit we, input logic [15:0] a,
                         input logic [15:0] wd, output int lat, output logic [15:0] rd);
    if (pd) begin d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; end
    else begin if_addr = a; if_req = 1'b1; end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (pd ? d_ack : if_ack) begin lat = c; break; end
      if (c == 1) begin
        if (pd) begin
          d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom_range(0, 1));
        end else if_addr = 16'($urandom);
      end
    end
    rd = pd ? d_rdata : if_rdata;
    d_req = 1'b0; if_req = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    checks++; if ({ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes got=%b exp=11111", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}); end
    checks++; if (ram_dout_en !== 1'b0) begin errors++; $display("FAIL reset_dout_en got=%b exp=0", ram_dout_en); end
    checks++; if (ram_addr !== 18'h0) begin errors++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (ram_dout !== 16'h0) begin errors++; $display("FAIL reset_ram_dout got=%h exp=0", ram_dout); end
    checks++; if ({if_rdata, d_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata); end
    checks++; if ({if_ack, d_ack, busy} !== 3'b000) begin errors++; $display("FAIL reset_ack_busy got=%b exp=000", {if_ack, d_ack, busy}); end
    RST = 1'b1;
    exp_if = '0; exp_d = '0; ref_last = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int lat, e0, o0, i0, r0;
    logic [15:0] rd;
    e0 = n_en; o0 = n_oe; i0 = n_iack;
    ref_apply(1'b0, 1'b0, 16'h0010, 16'h0);
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0, lat, rd);
    checks++; if (lat != 3) begin errors++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL fetch_rdata got=%h exp=1234", rd); end
    checks++; if (n_en - e0 != 2 || n_oe - o0 != 2) begin
      errors++; $display("FAIL fetch_en_oe_cycles got=%0d/%0d exp=2/2", n_en - e0, n_oe - o0); end
    checks++; if (rd_addr !== 18'h00010) begin errors++; $display("FAIL fetch_ram_addr got=%h exp=00010", rd_addr); end
    checks++; if (n_iack - i0 != 1) begin errors++; $display("FAIL fetch_ack_pulse got=%0d exp=1", n_iack - i0); end
    // A fetch from the UART data address is still an SRAM read.
    r0 = n_rdn; e0 = n_en;
    ref_apply(1'b0, 1'b0, UDATA, 16'h0);
    run_txn(1'b0, 1'b0, UDATA, 16'h0, lat, rd);
    checks++; if (rd !== exp_if || n_rdn != r0 || n_en - e0 != 2) begin
      errors++; $display("FAIL fetch_uart_addr got=%h rdn=%0d en=%0d exp=%h 0 2", rd, n_rdn - r0, n_en - e0, exp_if); end
  endtask

  task automatic test_sram_write();
    int lat, w0, d0, e0;
    logic [15:0] rd;
    w0 = n_we; d0 = n_dout; e0 = n_en;
    ref_apply(1'b1, 1'b1, 16'h8000, 16'hABCD);
    run_txn(1'b1, 1'b1, 16'h8000, 16'hABCD, lat, rd);
    checks++; if (lat != NP + 3) begin errors++; $display("FAIL wr_latency got=%0d exp=%0d", lat, NP + 3); end
    checks++; if (n_we - w0 != NP) begin errors++; $display("FAIL wr_we_cycles got=%0d exp=%0d", n_we - w0, NP); end
    checks++; if (n_dout - d0 != NP + 2 || n_en - e0 != NP + 2) begin
      errors++; $display("FAIL wr_dout_en_cycles got=%0d/%0d exp=%0d", n_dout - d0, n_en - e0, NP + 2); end
    checks++; if (we_dout !== 16'hABCD) begin errors++; $display("FAIL wr_dout got=%h exp=abcd", we_dout); end
    checks++; if (rd !== exp_d) begin errors++; $display("FAIL wr_rdata_kept got=%h exp=%h", rd, exp_d); end
    ref_apply(1'b1, 1'b0, 16'h8000, 16'h0);
    run_txn(1'b1, 1'b0, 16'h8000, 16'h0, lat, rd);
    checks++; if (rd !== 16'hABCD || lat != 3) begin
      errors++; $display("FAIL wr_readback got=%h lat=%0d exp=abcd lat=3", rd, lat); end
  endtask

  task automatic test_status();
    int lat, e0;
    logic [15:0] rd;
    e0 = n_en;
    uart_tbre = 1'b1; uart_tsre = 1'b1; uart_data_ready = 1'b1;
    ref_apply(1'b1, 1'b0, USTAT, 16'h0);
    run_txn(1'b1, 1'b0, USTAT, 16'h0, lat, rd);
    checks++; if (lat != 1 || rd !== 16'h0003) begin
      errors++; $display("FAIL status_all_set got=%h lat=%0d exp=0003 lat=1", rd, lat); end
    uart_tsre = 1'b0; uart_data_ready = 1'b0;
    ref_apply(1'b1, 1'b0, USTAT, 16'h0);
    run_txn(1'b1, 1'b0, USTAT, 16'h0, lat, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL status_clear got=%h exp=0000", rd); end
    for (int i = 0; i < 4; i++) begin
      uart_tbre = 1'($urandom_range(0, 1)); uart_tsre = 1'($urandom_range(0, 1));
      uart_data_ready = 1'($urandom_range(0, 1));
      ref_apply(1'b1, 1'b0, USTAT, 16'h0);
      run_txn(1'b1, 1'b0, USTAT, 16'h0, lat, rd);
      checks++; if (rd !== exp_d) begin errors++; $display("FAIL status_rand got=%h exp=%h", rd, exp_d); end
    end
    ref_apply(1'b1, 1'b1, USTAT, 16'hFFFF);
    run_txn(1'b1, 1'b1, USTAT, 16'hFFFF, lat, rd);
    checks++; if (lat != 1 || rd !== exp_d || n_en != e0) begin
      errors++; $display("FAIL status_write got=%h lat=%0d en=%0d exp=%h lat=1 en=0", rd, lat, n_en - e0, exp_d); end
  endtask

  task automatic test_uart();
    int lat, w0, e0, d0, r0;
    logic [15:0] rd;
    w0 = n_wrn; e0 = n_en; d0 = n_dout;
    ref_apply(1'b1, 1'b1, UDATA, 16'h1241);
    run_txn(1'b1, 1'b1, UDATA, 16'h1241, lat, rd);
    checks++; if (lat != NP + 2) begin errors++; $display("FAIL uw_latency got=%0d exp=%0d", lat, NP + 2); end
    checks++; if (n_wrn - w0 != NP || wrn_dout !== 16'h0041) begin
      errors++; $display("FAIL uw_pulse got=%0d/%h exp=%0d/0041", n_wrn - w0, wrn_dout, NP); end
    checks++; if (n_en != e0 || n_dout - d0 != NP + 1) begin
      errors++; $display("FAIL uw_bus got en=%0d dout=%0d exp=0 %0d", n_en - e0, n_dout - d0, NP + 1); end
    r0 = n_rdn;
    uart_bus = 16'hFF5A;
    ref_apply(1'b1, 1'b0, UDATA, 16'h0);
    run_txn(1'b1, 1'b0, UDATA, 16'h0, lat, rd);
    checks++; if (rd !== 16'h005A || lat != 3) begin errors++; $display("FAIL ur_rdata got=%h lat=%0d exp=005a lat=3", rd, lat); end
    checks++; if (n_rdn - r0 != 2 || n_en != e0) begin
      errors++; $display("FAIL ur_strobes got rdn=%0d en=%0d exp=2 0", n_rdn - r0, n_en - e0); end
  endtask

  task automatic test_random();
    int lat, e0, w0, wr0, r0, el;
    bit pd, we, sram;
    logic [15:0] a, wd, rd, ex;
    for (int i = 0; i < 24; i++) begin
      pd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = UDATA;
        1:       a = USTAT;
        default: a = 16'h0100 + 16'($urandom_range(0, 7));
      endcase
      we = pd ? 1'($urandom_range(0, 1)) : 1'b0;
      wd = 16'($urandom);
      uart_bus = 16'($urandom);
      uart_tbre = 1'($urandom_range(0, 1)); uart_tsre = 1'($urandom_range(0, 1));
      uart_data_ready = 1'($urandom_range(0, 1));
      sram = !pd || (a != UDATA && a != USTAT);
      e0 = n_en; w0 = n_we; wr0 = n_wrn; r0 = n_rdn;
      el = exp_lat(pd, we, a);
      ref_apply(pd, we, a, wd);
      ex = pd ? exp_d : exp_if;
      run_txn(pd, we, a, wd, lat, rd);
      checks++; if (lat != el || rd !== ex) begin
        errors++; $display("FAIL rand_txn%0d pd=%0d we=%0d a=%h got=%h lat=%0d exp=%h lat=%0d", i, pd, we, a, rd, lat, ex, el); end
      checks++; if (n_en - e0 != (sram ? ((pd && we) ? NP + 2 : 2) : 0)
                 || n_we - w0 != ((sram && pd && we) ? NP : 0)
                 || n_wrn - wr0 != ((pd && a == UDATA && we) ? NP : 0)
                 || n_rdn - r0 != ((pd && a == UDATA && !we) ? 2 : 0)) begin
        errors++; $display("FAIL rand_strobes%0d got en=%0d we=%0d wrn=%0d rdn=%0d", i, n_en - e0, n_we - w0, n_wrn - wr0, n_rdn - r0); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c_if_a, c_d_a, c_d_wd;
    bit c_d_we, exp_next;
    int cyc, prev, acks, el;
    c_if_a = 16'h0100 + 16'($urandom_range(0, 7));
    c_d_a  = 16'h0100 + 16'($urandom_range(0, 7));
    c_d_we = 1'($urandom_range(0, 1)); c_d_wd = 16'($urandom);
    if_addr = c_if_a; d_addr = c_d_a; d_we = c_d_we; d_wdata = c_d_wd;
    if_req = 1'b1; d_req = 1'b1;
    exp_next = ref_last ? 1'b0 : 1'b1;
    cyc = 0; prev = 0; acks = 0;
    while (acks < 8 && cyc < 300) begin
      tick();
      cyc++;
      if (if_ack || d_ack) begin
        checks++; if ({d_ack, if_ack} !== (exp_next ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL b2b_order%0d got d/if=%b exp=%b", acks, {d_ack, if_ack}, exp_next ? 2'b10 : 2'b01); end
        el = exp_next ? exp_lat(1'b1, c_d_we, c_d_a) : 3;
        checks++; if (cyc - prev != (acks == 0 ? 0 : 1) + el) begin
          errors++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", acks, cyc - prev, (acks == 0 ? 0 : 1) + el); end
        if (exp_next) begin
          ref_apply(1'b1, c_d_we, c_d_a, c_d_wd);
          checks++; if (d_rdata !== exp_d) begin errors++; $display("FAIL b2b_d_rdata%0d got=%h exp=%h", acks, d_rdata, exp_d); end
          c_d_a  = 16'h0100 + 16'($urandom_range(0, 7));
          c_d_we = 1'($urandom_range(0, 1)); c_d_wd = 16'($urandom);
          d_addr = c_d_a; d_we = c_d_we; d_wdata = c_d_wd;
        end else begin
          ref_apply(1'b0, 1'b0, c_if_a, 16'h0);
          checks++; if (if_rdata !== exp_if) begin errors++; $display("FAIL b2b_if_rdata%0d got=%h exp=%h", acks, if_rdata, exp_if); end
          c_if_a = 16'h0100 + 16'($urandom_range(0, 7));
          if_addr = c_if_a;
        end
        exp_next = ref_last ? 1'b0 : 1'b1;
        prev = cyc;
        acks++;
        if (acks == 8) begin if_req = 1'b0; d_req = 1'b0; end
      end
    end
    checks++; if (acks != 8) begin errors++; $display("FAIL b2b_timeout got=%0d acks exp=8", acks); end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, a0;
    bit reached;
    logic [15:0] rd;
    reached = 1'b0;
    d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h5555; d_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!ram_we_n) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach got=no we pulse exp=pulse"); end
    a0 = n_dack;
    RST = 1'b0;
    #1;
    checks++; if ({ram_we_n, ram_en_n, ram_dout_en, busy} !== 4'b1100) begin
      errors++; $display("FAIL rstmid_release got=%b exp=1100", {ram_we_n, ram_en_n, ram_dout_en, busy}); end
    repeat (2) tick();
    d_req = 1'b0;
    RST = 1'b1;
    exp_if = '0; exp_d = '0; ref_last = 1'b0;
    repeat (3) tick();
    checks++; if (n_dack != a0) begin errors++; $display("FAIL rstmid_no_ack got=%0d acks exp=0", n_dack - a0); end
    ref_apply(1'b0, 1'b0, 16'h0010, 16'h0);
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0, lat, rd);
    checks++; if (rd !== 16'h1234 || lat != 3 || d_rdata !== exp_d) begin
      errors++; $display("FAIL rstmid_fetch got=%h lat=%0d d=%h exp=1234 lat=3 d=%h", rd, lat, d_rdata, exp_d); end
  endtask

  initial begin
    RST = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    uart_data_ready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0; uart_bus = '0;
    test_reset();
    test_fetch();
    test_sram_write();
    test_status();
    test_uart();
    test_random();
    test_back_to_back();
    test_reset_mid();
    checks++; if (n_conflict != 0) begin
      errors++; $display("FAIL bus_oe_conflict got=%0d cycles exp=0", n_conflict); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
